// File: rtl/spad_pkg.sv
// Shared types for the scratchpad window reader.
// Holds the controller state encoding and the output skid buffer depth.
package spad_pkg;
   typedef enum logic [2:0] {IDLE, READ, DRAIN, DONE, ERR} state_t;
   localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/spad_window_reader_if.sv
// Output stream bundle of the window reader.
// Carries data, valid, ready and last; the master drives everything except ready.
interface spad_window_reader_if #(
   parameter int DATA_WIDTH = 3
) ();
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/spad_out_skid.sv
// Two-entry FIFO of {last, data} that absorbs the scratchpad read latency.
// The head is combinational and reads as zero while the buffer is empty.
module spad_out_skid
   import spad_pkg::*;
#(
   parameter int DATA_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   input  logic                  i_pop,
   output logic [1:0]            o_count,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last
);
   logic [DATA_WIDTH:0] r_mem [SKID_DEPTH];
   logic                r_wr_ptr;
   logic                r_rd_ptr;
   logic [1:0]          r_count;
   logic [DATA_WIDTH:0] w_head;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) r_wr_ptr <= ~r_wr_ptr;
         if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + 2'(i_push) - 2'(i_pop);
      end
   end

   // Storage carries no reset; the head is masked by the occupancy count.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= {i_last, i_data};
   end

   assign w_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;
   assign o_valid = (r_count != 2'd0);
   assign o_data  = w_head[DATA_WIDTH-1:0];
   assign o_last  = w_head[DATA_WIDTH];
endmodule

// File: rtl/spad_window_reader.sv
// Streams win_len consecutive scratchpad words from base_addr, wrapping at DEPTH.
// Reads are throttled so the 2-entry skid plus the in-flight read never overflow.
module spad_window_reader
   import spad_pkg::*;
#(
   parameter int DATA_WIDTH = 3,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 10,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  win_len,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  spad_chip_en,
   output logic                  spad_ren,
   output logic [ADDR_WIDTH-1:0] spad_raddr,
   input  logic [DATA_WIDTH-1:0] spad_dout,
   spad_window_reader_if.master  o_strm
);
   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_issued;
   logic                  r_infl;
   logic                  r_infl_last;
   logic                  r_bad_base;

   logic [1:0]            w_count;
   logic                  w_valid;
   logic                  w_head_last;
   logic                  w_pop;
   logic [2:0]            w_occ;
   logic                  w_ren;
   logic                  w_last_issue;
   logic                  w_bad_base;
   logic [ADDR_WIDTH-1:0] w_next_addr;

   spad_out_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_infl),
      .i_data  (spad_dout),
      .i_last  (r_infl_last),
      .i_pop   (w_pop),
      .o_count (w_count),
      .o_valid (w_valid),
      .o_data  (o_strm.out_data),
      .o_last  (w_head_last)
   );

   assign w_pop = w_valid & o_strm.out_ready;
   // Occupancy credits a same-cycle pop so a steady ready stream sustains one word per cycle.
   assign w_occ        = 3'(w_count) + 3'(r_infl) - 3'(w_pop);
   assign w_ren        = (r_state == READ) && (w_occ < 3'd2);
   assign w_last_issue = (r_issued == r_len - LEN_WIDTH'(1));
   assign w_bad_base   = (32'(base_addr) >= 32'(DEPTH));
   assign w_next_addr  = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_len       <= '0;
         r_issued    <= '0;
         r_infl      <= 1'b0;
         r_infl_last <= 1'b0;
         r_bad_base  <= 1'b0;
      end else begin
         r_infl      <= w_ren;
         r_infl_last <= w_ren && w_last_issue;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_len      <= win_len;
                  r_addr     <= base_addr;
                  r_issued   <= '0;
                  r_bad_base <= w_bad_base;
                  r_state    <= (w_bad_base || win_len == '0) ? ERR : READ;
               end
            end
            READ: begin
               if (w_ren) begin
                  r_addr   <= w_next_addr;
                  r_issued <= r_issued + LEN_WIDTH'(1);
                  if (w_last_issue) r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_pop && w_head_last) r_state <= DONE;
            end
            DONE:    r_state <= IDLE;
            ERR:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy             = (r_state == READ) || (r_state == DRAIN);
   assign done             = (r_state == DONE) || (r_state == ERR);
   assign err              = (r_state == ERR) && r_bad_base;
   assign spad_chip_en     = busy;
   assign spad_ren         = w_ren;
   assign spad_raddr       = w_ren ? r_addr : '0;
   assign o_strm.out_valid = w_valid;
   assign o_strm.out_last  = w_head_last;
endmodule
